// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared types and helpers for the data-memory responder:
//   - mem_size_e / dmem_state_e enums
//   - dmem_req_t / dmem_rsp_t bundles
//   - size decode, byte-lane mask, store steering, load extraction,
//     misalignment detection
package dmem_responder_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic          we;
    mem_size_e     size;
    logic          is_unsigned;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } dmem_rsp_t;

  // Raw encoding 3 is folded onto WORD.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    mem_size_e s;
    case (raw)
      2'd0:    s = BYTE;
      2'd1:    s = HALF;
      default: s = WORD;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] lane_mask(input mem_size_e size,
                                           input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      BYTE:    m = 4'b0001 << lane;
      HALF:    m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicating the right-aligned data across lanes lets the byte mask
  // alone pick which bytes land.
  function automatic logic [DW-1:0] steer_wdata(input mem_size_e size,
                                                input logic [DW-1:0] wdata);
    logic [DW-1:0] d;
    case (size)
      BYTE:    d = {4{wdata[7:0]}};
      HALF:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                 input mem_size_e size,
                                                 input logic [1:0] lane,
                                                 input logic is_unsigned);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      BYTE:    r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      HALF:    r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size,
                                         input logic [1:0] lane);
    logic m;
    case (size)
      BYTE:    m = 1'b0;
      HALF:    m = lane[0];
      default: m = |lane;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between the memory stage (master) and the
//   data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we/size/unsigned/addr/wdata : request payload
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : response payload
interface dmem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram
//   Word-organised storage with per-byte write enables and a combinational
//   read port sharing the same word index. Contents are not reset.
//   clk_i   : write clock
//   we_i    : per-byte write enables
//   idx_i   : word index (read and write)
//   wdata_i : lane-steered write data
//   rdata_o : word at idx_i
module dmem_byte_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned WORDS = 256
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o
);

  logic [3:0][7:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[idx_i][b] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder end of the memory-stage data-memory interface. Accepts one
//   load/store at a time, models a fixed LATENCY, holds the response until
//   accepted, and performs byte/half/word lane steering with extension.
//   clk    : clock, rising edge
//   arst_n : asynchronous active-low reset
//   bus    : dmem_responder_if slave modport (request + response)
//   Parameters: DATA_WIDTH (32 only), DMEM_SZ_IN_KB, LATENCY (>= 1).
//   Build option: DMEM_MISALIGN_TRAP_EN -- misaligned HALF/WORD accesses
//   skip the storage write and respond with rsp_err=1, rsp_rdata=0.
//   Without it misaligned low address bits are ignored and rsp_err is 0.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DMEM_SZ_IN_KB = 1,
  parameter int unsigned LATENCY       = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DMEM_SZ_IN_KB * 1024);
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned WORDS  = (DMEM_SZ_IN_KB * 1024) / 4;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  dmem_rsp_t             rsp_q, rsp_d;
  dmem_req_t             in_req;
  dmem_req_t             cur_req;
  logic                  enter_resp;
  logic                  trap;
  logic [3:0]            ram_we;
  logic [IDX_W-1:0]      ram_idx;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr_hi;

  always_comb begin : in_pack
    in_req.we          = bus.req_we;
    in_req.size        = decode_size(bus.req_size);
    in_req.is_unsigned = bus.req_unsigned;
    in_req.addr        = bus.req_addr;
    in_req.wdata       = bus.req_wdata;
  end

  // With LATENCY==1 RESP is entered on the accept edge itself, so the
  // commit/read must use the live request rather than the latched copy.
  assign cur_req = (state_q == IDLE) ? in_req : req_q;

  // Bits above the storage size are ignored: addresses wrap.
  assign ram_idx        = cur_req.addr[ADDR_W-1:2];
  assign unused_addr_hi = ^cur_req.addr[DW-1:ADDR_W];

  always_ff @(posedge clk or negedge arst_n) begin : state_reg
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d = in_req;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage commit and response capture both occur on the edge entering RESP.
  always_comb begin : datapath
    enter_resp = (state_d == RESP) && (state_q != RESP);
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = is_misaligned(cur_req.size, cur_req.addr[1:0]);
`else
    trap = 1'b0;
`endif
    ram_we = '0;
    if (enter_resp && cur_req.we && !trap) begin
      ram_we = lane_mask(cur_req.size, cur_req.addr[1:0]);
    end
    rsp_d = rsp_q;
    if (enter_resp) begin
      rsp_d.err   = trap;
      rsp_d.rdata = (cur_req.we || trap) ? '0 :
                    load_extract(ram_rdata, cur_req.size, cur_req.addr[1:0],
                                 cur_req.is_unsigned);
    end
  end

  always_comb begin : fsm_out
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rsp_q.rdata;
    bus.rsp_err   = rsp_q.err;
  end

  dmem_byte_ram #(
    .IDX_W (IDX_W),
    .WORDS (WORDS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .idx_i   (ram_idx),
    .wdata_i (steer_wdata(cur_req.size, cur_req.wdata)),
    .rdata_o (ram_rdata)
  );

endmodule
